irq_controller: RTL and testbench

- Upstream front-end of the interrupt sequencer.
- Synchronises eight asynchronous peripheral interrupt lines and applies per-line edge/level mode.
- Holds pending and enable registers, and presents one stable one-hot request of the highest-priority line to the sequencer's `interrupts[7:0]` input.
- Observes the sequencer's busy (`interrupt`) flag to acknowledge the granted line, and exposes a small memory-mapped register file to the CPU.

---
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_controller.sv | 144 ++++++++++++++
 tb/tb_irq_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Signal bundle between the interrupt front-end, its peripheral lines, the sequencer and the CPU register bus.
// slave is the controller side; master is whoever drives the lines, the sequencer flag and the bus.
interface irq_controller_if #(
  parameter int NLINES = 8
);
  logic [NLINES-1:0]         irq_in;
  logic                      seq_busy;
  logic [1:0]                bus_addr;
  logic [7:0]                bus_wdata;
  logic                      bus_we;
  logic [7:0]                bus_rdata;
  logic [NLINES-1:0]         irq_out;
  logic [$clog2(NLINES)-1:0] irq_id;

  modport slave (
    input  irq_in, seq_busy, bus_addr, bus_wdata, bus_we,
    output bus_rdata, irq_out, irq_id
  );

  modport master (
    output irq_in, seq_busy, bus_addr, bus_wdata, bus_we,
    input  bus_rdata, irq_out, irq_id
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt front-end: synchronises lines, keeps pending/enable state, presents one held one-hot request to the sequencer.
// Request appears SYNC_STAGES+1 cycles after a line rises; it is held until seq_busy acks it or the line/GIE is masked.
module irq_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int NLINES      = 8
) (
  input  logic            CLK,
  input  logic            RST,
  irq_controller_if.slave bus
);
  localparam int IDW = $clog2(NLINES);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

  state_t            state_q, state_d;
  logic [NLINES-1:0] sync_q [SYNC_STAGES];
  logic [NLINES-1:0] s, s_prev_q, rise;
  logic [NLINES-1:0] enable_q, enable_d;
  logic [NLINES-1:0] pending_q, pending_d;
  logic [NLINES-1:0] edge_sel_q, edge_sel_d;
  logic              gie_q, gie_d;
  logic [IDW-1:0]    last_id_q, last_id_d;
  logic [NLINES-1:0] irq_out_q, irq_out_d;
  logic [IDW-1:0]    irq_id_q, irq_id_d;
  logic [NLINES-1:0] cand, ack_mask, w1c_mask;
  logic [IDW-1:0]    win;
  logic              ack;
  logic              wr_enable, wr_pending, wr_edge, wr_ctrl;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_prev_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_prev_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;

  assign wr_enable  = bus.bus_we && (bus.bus_addr == 2'd0);
  assign wr_pending = bus.bus_we && (bus.bus_addr == 2'd1);
  assign wr_edge    = bus.bus_we && (bus.bus_addr == 2'd2);
  assign wr_ctrl    = bus.bus_we && (bus.bus_addr == 2'd3);

  assign cand = pending_q & enable_q;

  // Descending scan so the lowest set index is the last assignment and wins.
  always_comb begin
    win = '0;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (cand[i]) win = IDW'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A request is never raised while the sequencer still reports busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gie_q && (cand != '0) && !bus.seq_busy) state_d = PRESENT;
      PRESENT: begin
        if (bus.seq_busy)                       state_d = SERVICE;
        else if (!gie_q || !enable_q[irq_id_q]) state_d = IDLE;
      end
      SERVICE: if (!bus.seq_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_out_d = '0;
    irq_id_d  = irq_id_q;
    last_id_d = last_id_q;
    ack       = 1'b0;
    case (state_q)
      IDLE: begin
        if (state_d == PRESENT) begin
          irq_out_d = NLINES'(1) << win;
          irq_id_d  = win;
        end
      end
      PRESENT: begin
        if (state_d == PRESENT) begin
          irq_out_d = irq_out_q;
        end else if (state_d == SERVICE) begin
          ack       = 1'b1;
          last_id_d = irq_id_q;
        end
      end
      default: ;
    endcase
  end

  assign ack_mask = ack ? (NLINES'(1) << irq_id_q) : '0;
  assign w1c_mask = wr_pending ? bus.bus_wdata : '0;

  // Edge lines: new edge overrides a same-cycle clear; level lines simply mirror the synchronised input.
  assign pending_d  = (edge_sel_q & ((pending_q & ~w1c_mask & ~ack_mask) | rise))
                    | (~edge_sel_q & s);
  assign enable_d   = wr_enable ? bus.bus_wdata : enable_q;
  assign edge_sel_d = wr_edge ? bus.bus_wdata : edge_sel_q;
  assign gie_d      = wr_ctrl ? bus.bus_wdata[0] : gie_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enable_q   <= '0;
      pending_q  <= '0;
      edge_sel_q <= '0;
      gie_q      <= 1'b0;
      last_id_q  <= '0;
      irq_out_q  <= '0;
      irq_id_q   <= '0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      edge_sel_q <= edge_sel_d;
      gie_q      <= gie_d;
      last_id_q  <= last_id_d;
      irq_out_q  <= irq_out_d;
      irq_id_q   <= irq_id_d;
    end
  end

  always_comb begin
    bus.bus_rdata = '0;
    case (bus.bus_addr)
      2'd0:    bus.bus_rdata = enable_q;
      2'd1:    bus.bus_rdata = pending_q;
      2'd2:    bus.bus_rdata = edge_sel_q;
      default: bus.bus_rdata = {(state_q == SERVICE), 3'b000, last_id_q, gie_q};
    endcase
  end

  assign bus.irq_out = irq_out_q;
  assign bus.irq_id  = irq_id_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized pending/enable sets, checked by a scoreboard.
`timescale 1ns/1ps
module tb_irq_controller;
  logic clk = 1'b0;
  logic rst;

  irq_controller_if #(.NLINES(8)) bus ();

  irq_controller #(.SYNC_STAGES(2), .NLINES(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         grant_q[$];
  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic       rd_vld = 1'b0;
  logic [7:0] prev_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Grant monitor: each new request is matched against the next expected line.
  always begin : grant_mon
    int e;
    @(posedge clk);
    #2;
    if (!rst) begin
      check("onehot", bus.irq_out & (bus.irq_out - 8'd1), 0);
      check("no_req_while_busy", bus.seq_busy ? bus.irq_out : 8'd0, 0);
      if (bus.irq_out != 8'd0 && prev_out == 8'd0) begin
        if (grant_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_grant: got 0x%0h, expected no request", bus.irq_out);
        end else begin
          e = grant_q.pop_front();
          check("grant_out", bus.irq_out, 32'd1 << e);
          check("grant_id", bus.irq_id, e);
        end
      end
    end
    prev_out = bus.irq_out;
  end

  always @(posedge rd_vld) begin
    #1;
    if (rd_exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL read_underflow: got 0x%0h, expected a queued read", bus.bus_rdata);
    end else begin
      check(rd_name_q.pop_front(), bus.bus_rdata, rd_exp_q.pop_front());
    end
  end

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string n);
    @(negedge clk);
    bus.bus_addr = a;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(n);
    rd_vld = 1'b1;
    #2;
    rd_vld = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    bus.bus_we    = 1'b1;
    @(negedge clk);
    bus.bus_we    = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    bus.irq_in = m;
    @(negedge clk);
    bus.irq_in = 8'h00;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.irq_out != 8'd0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: got no request in 60 cycles, expected one");
    end
  endtask

  // Sequencer stand-in: acks the presented line, optionally releasing level lines while busy.
  task automatic service(input int id, input bit drop_lvl);
    bit ok;
    wait_grant(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.seq_busy = 1'b1;
    rd(2'd3, 8'h81 | 8'(id << 1), "svc_ctrl");
    if (drop_lvl) begin
      bus.irq_in = 8'h00;
      repeat (6) @(negedge clk);
    end else begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus.seq_busy = 1'b0;
    @(negedge clk);
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] en, m, p;
    int         order[$];
    bit         ok;

    rst = 1'b1;
    bus.irq_in = 8'h00; bus.seq_busy = 1'b0;
    bus.bus_addr = 2'd0; bus.bus_wdata = 8'h00; bus.bus_we = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_irq_out", bus.irq_out, 0);
    check("rst_irq_id", bus.irq_id, 0);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) rd(2'(a), 8'h00, "rst_reg");

    // Single edge line with exact latency.
    wr(2'd0, 8'h08); wr(2'd2, 8'h08); wr(2'd3, 8'h01);
    grant_q.push_back(3);
    @(negedge clk); bus.irq_in = 8'h08;
    @(posedge clk); #1 check("lat_k", bus.irq_out, 0);
    @(negedge clk); bus.irq_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 check("lat_k2", bus.irq_out, 0);
    @(posedge clk);
    #1 check("lat_k3", bus.irq_out, 8'h08);
    check("lat_id", bus.irq_id, 3);
    @(negedge clk); bus.seq_busy = 1'b1;
    @(posedge clk); #1 check("ack_out", bus.irq_out, 0);
    rd(2'd1, 8'h00, "ack_pending");
    rd(2'd3, 8'h87, "ack_ctrl");
    @(negedge clk); bus.seq_busy = 1'b0;
    rd(2'd3, 8'h07, "done_ctrl");

    // Priority and hold during PRESENT.
    wr(2'd0, 8'hFF); wr(2'd2, 8'hFF);
    grant_q.push_back(2); grant_q.push_back(0); grant_q.push_back(5);
    pulse(8'h24);
    wait_grant(ok);
    pulse(8'h01);
    repeat (4) @(negedge clk);
    check("hold_out", bus.irq_out, 8'h04);
    check("hold_id", bus.irq_id, 2);
    service(2, 1'b0); service(0, 1'b0); service(5, 1'b0);

    // Level line re-requests until released.
    wr(2'd0, 8'h02); wr(2'd2, 8'h00);
    grant_q.push_back(1); grant_q.push_back(1);
    @(negedge clk); bus.irq_in = 8'h02;
    service(1, 1'b0);
    service(1, 1'b1);
    repeat (10) @(negedge clk);
    check("lvl_release", bus.irq_out, 0);
    rd(2'd1, 8'h00, "lvl_pending");

    // Masking, then GIE dropped while presenting.
    wr(2'd2, 8'hFF); wr(2'd0, 8'h00);
    pulse(8'h10);
    repeat (5) @(negedge clk);
    check("mask_out", bus.irq_out, 0);
    rd(2'd1, 8'h10, "mask_pending");
    grant_q.push_back(4);
    wr(2'd0, 8'h10);
    wait_grant(ok);
    wr(2'd3, 8'h00);
    @(posedge clk); #1 check("gie_drop_out", bus.irq_out, 0);
    rd(2'd1, 8'h10, "gie_drop_pending");
    rd(2'd3, 8'h02, "gie_drop_ctrl");
    wr(2'd1, 8'h10);
    rd(2'd1, 8'h00, "w1c_clear");

    // W1C landing on the same edge that latches a new line-2 edge.
    wr(2'd0, 8'h00);
    @(negedge clk); bus.irq_in = 8'h04;
    @(negedge clk); bus.irq_in = 8'h00;
    @(negedge clk); bus.bus_addr = 2'd1; bus.bus_wdata = 8'h04; bus.bus_we = 1'b1;
    @(negedge clk); bus.bus_we = 1'b0;
    rd(2'd1, 8'h04, "collide_pending");
    wr(2'd1, 8'h04);
    rd(2'd1, 8'h00, "collide_clear");

    // Random pending/enable sets: grants drain in ascending index order of the enabled subset.
    for (int it = 0; it < 24; it++) begin
      en = 8'($urandom_range(0, 255));
      m  = 8'($urandom_range(1, 255));
      wr(2'd3, 8'h00); wr(2'd0, en);
      pulse(m);
      repeat (4) @(negedge clk);
      rd(2'd1, m, "rnd_pending");
      p = m;
      order.delete();
      while ((p & en) != 8'h00) begin
        order.push_back(lowest(p & en));
        grant_q.push_back(order[$]);
        p &= ~(8'd1 << order[$]);
      end
      wr(2'd3, 8'h01);
      foreach (order[i]) service(order[i], 1'b0);
      repeat (3) @(negedge clk);
      rd(2'd1, p, "rnd_residue");
      wr(2'd1, 8'hFF);
      rd(2'd1, 8'h00, "rnd_clear");
    end

    // Asynchronous reset while the sequencer is servicing.
    wr(2'd0, 8'hFF); wr(2'd3, 8'h01);
    grant_q.push_back(6);
    pulse(8'hC0);
    wait_grant(ok);
    @(negedge clk); bus.seq_busy = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("arst_out", bus.irq_out, 0);
    check("arst_id", bus.irq_id, 0);
    rd(2'd1, 8'h00, "arst_pending");
    rd(2'd3, 8'h00, "arst_ctrl");
    @(negedge clk); rst = 1'b0; bus.seq_busy = 1'b0;
    rd(2'd0, 8'h00, "post_rst_enable");
    rd(2'd2, 8'h00, "post_rst_edge");
    rd(2'd1, 8'h00, "post_rst_pending");
    rd(2'd3, 8'h00, "post_rst_ctrl");
    repeat (10) @(negedge clk);
    check("post_rst_quiet", bus.irq_out, 0);

    check("grants_left", grant_q.size(), 0);
    check("reads_left", rd_exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
